truth_table_sweeper: RTL and testbench

Sequential readout block for a synthesized 4-input logic circuit: it drives all 16 input combinations onto the circuit under test, waits a programmable settle time, samples the single circuit output three times with majority vote, and assembles the measured 16-bit truth table. It sits between a control host and one circuit instance, and compares the measured table against an expected hex value such as 0x3B68. It is the observing and verifying end of a combinational gate netlist's input/output interface.

---
 rtl/tts_pkg.sv | 21 ++
 rtl/truth_table_sweeper_sync2.sv | 26 ++
 rtl/truth_table_sweeper.sv | 132 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
//   state_t      : sweep FSM states
//   N_IN         : circuit input width
//   N_VEC        : number of input combinations swept
//   N_SAMPLES    : samples taken per vector for the majority vote
//   VOTE_THRESH  : ones needed among N_SAMPLES to call the output high
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_IN        = 4;
    localparam int N_VEC       = 16;
    localparam int N_SAMPLES   = 3;
    localparam int VOTE_THRESH = 2;

endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// Two-flop synchronizer bringing the (possibly asynchronous) circuit output
// into the clk domain.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors of a 4-input circuit, lets each settle for
// SETTLE_CYCLES, majority-votes three samples of the output and publishes the
// measured truth table together with a comparison against a reference.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a sweep (only honoured in IDLE)
//   expected      : reference table, captured when start is accepted
//   dut_out       : circuit output (asynchronous)
//   dut_in        : vector applied to the circuit
//   busy          : sweep in progress (SETTLE/SAMPLE)
//   done          : one-cycle result-valid pulse
//   tt            : measured table, tt[i] = output for dut_in == i
//   match         : tt equals captured reference
//   mismatch_mask : tt ^ captured reference
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        dut_out,
    output logic [3:0]  dut_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic [15:0] mismatch_mask
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(N_SAMPLES - 1);
    localparam logic [3:0] IDX_LAST    = 4'(N_VEC - 1);

    state_t      state, state_next;
    logic [3:0]  idx;
    logic [7:0]  cnt;
    logic [1:0]  ones, ones_next;
    logic [15:0] shadow, shadow_next, expected_q;
    logic        out_sync;
    logic        last_sample;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_out),
        .q   (out_sync)
    );

    assign last_sample = (state == SAMPLE) && (cnt == SAMPLE_LAST);
    assign ones_next   = ones + {1'b0, out_sync};

    // Shadow table with the current vector's vote folded in, so the final
    // vector can go straight to the published outputs on the DONE transition.
    always_comb begin
        shadow_next      = shadow;
        shadow_next[idx] = (ones_next >= 2'(VOTE_THRESH));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = SETTLE;
            SETTLE: if (cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE: if (last_sample) state_next = (idx == IDX_LAST) ? DONE : SETTLE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            cnt           <= '0;
            ones          <= '0;
            shadow        <= '0;
            expected_q    <= '0;
            dut_in        <= '0;
            tt            <= '0;
            match         <= 1'b0;
            mismatch_mask <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    expected_q <= expected;
                    idx        <= '0;
                    dut_in     <= '0;
                    cnt        <= '0;
                    shadow     <= '0;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt  <= '0;
                        ones <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    ones <= ones_next;
                    cnt  <= cnt + 8'd1;
                    if (last_sample) begin
                        shadow <= shadow_next;
                        cnt    <= '0;
                        if (idx == IDX_LAST) begin
                            // Results land together with the DONE state so
                            // they are valid in the same cycle as done.
                            tt            <= shadow_next;
                            match         <= (shadow_next == expected_q);
                            mismatch_mask <= shadow_next ^ expected_q;
                        end else begin
                            idx    <= idx + 4'd1;
                            dut_in <= idx + 4'd1;
                        end
                    end
                end
                DONE: dut_in <= '0;
                default: ;
            endcase
        end
    end

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. The circuit under test is a
// LUT (0x3B68) indexed by dut_in, with an optional inversion to model
// glitches. Each accepted sweep pushes its expected result to a scoreboard;
// a monitor pops and compares whenever done fires.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst, start, glitch;
    logic [15:0] expected, lut;
    logic        dut_out;
    logic [3:0]  dut_in;
    logic        busy, done, match;
    logic [15:0] tt, mismatch_mask;

    // second instance: minimum settle, constant-1 circuit
    logic        rst2, start2, one2;
    logic [15:0] expected2;
    logic [3:0]  dut_in2;
    logic        busy2, done2, match2;
    logic [15:0] tt2, mask2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0;

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [15:0] mask;
        int          c0;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_out = lut[dut_in] ^ glitch;

    truth_table_sweeper #(.SETTLE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
        .tt(tt), .match(match), .mismatch_mask(mismatch_mask)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .expected(expected2),
        .dut_out(one2), .dut_in(dut_in2), .busy(busy2), .done(done2),
        .tt(tt2), .match(match2), .mismatch_mask(mask2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding sweep.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tt", {16'd0, tt}, {16'd0, e.tt});
                check("match", {31'd0, match}, {31'd0, e.match});
                check("mismatch_mask", {16'd0, mismatch_mask}, {16'd0, e.mask});
                check("done_latency", cyc - e.c0, 16 * (8 + 3));
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic do_start(input logic [15:0] e, input bit push,
                            input logic [15:0] ett, input logic em, input logic [15:0] emask);
        exp_t it;
        @(negedge clk);
        start    = 1'b1;
        expected = e;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        if (push) begin
            it.tt = ett; it.match = em; it.mask = emask; it.c0 = c0;
            sb.push_back(it);
        end
    endtask

    task automatic wait_rel(input int n);
        while (cyc < c0 + n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Inversion is timed so the synchronizer's first flop captures it on
    // n consecutive edges, which then lands on the first n votes of vector 5.
    task automatic glitch_v5(input int n);
        wait_rel(5 * 11 + 6);
        glitch = 1'b1;
        repeat (n) @(negedge clk);
        glitch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; expected = '0; lut = 16'h3B68; glitch = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; expected2 = '0; one2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tt", {16'd0, tt}, 32'd0);
        check("rst_dut_in", {28'd0, dut_in}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_mask", {16'd0, mismatch_mask}, 32'd0);
        rst = 1'b0; rst2 = 1'b0;
        repeat (2) @(negedge clk);

        // matching sweep, with a look at busy and the vector stepping
        do_start(16'h3B68, 1, 16'h3B68, 1'b1, 16'h0000);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_rel(10);
        check("dut_in_before_step", {28'd0, dut_in}, 32'd0);
        wait_rel(11);
        check("dut_in_step1", {28'd0, dut_in}, 32'd1);
        drain();
        check("dut_in_idle", {28'd0, dut_in}, 32'd0);

        // one-bit mismatch; previous result must hold mid-sweep
        do_start(16'h3B69, 1, 16'h3B68, 1'b0, 16'h0001);
        wait_rel(50);
        check("tt_hold", {16'd0, tt}, 32'h3B68);
        check("match_hold", {31'd0, match}, 32'd1);
        drain();

        // single-sample glitch is outvoted; two samples flip the vote
        do_start(16'h3B68, 1, 16'h3B68, 1'b1, 16'h0000);
        glitch_v5(1);
        drain();
        do_start(16'h3B68, 1, 16'h3B48, 1'b0, 16'h0020);
        glitch_v5(2);
        drain();

        // start hammered and expected scrambled mid-sweep
        do_start(16'h3B68, 1, 16'h3B68, 1'b1, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            repeat (9) @(negedge clk);
            start    = 1'b1;
            expected = 16'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        drain();
        repeat (20) @(negedge clk);
        check("no_extra_done", sb.size(), 0);

        // reset mid-sweep clears everything immediately
        do_start(16'h3B68, 0, 16'h0, 1'b0, 16'h0);
        wait_rel(90);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_tt", {16'd0, tt}, 32'd0);
        check("midrst_dut_in", {28'd0, dut_in}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start(16'h3B68, 1, 16'h3B68, 1'b1, 16'h0000);
        drain();

        // minimum settle time, constant-1 circuit
        @(negedge clk);
        start2 = 1'b1; expected2 = 16'hFFFF;
        @(negedge clk);
        start2 = 1'b0; c0 = cyc;
        for (int i = 0; i < 200 && !done2; i++) @(negedge clk);
        check("s2_done_seen", {31'd0, done2}, 32'd1);
        check("s2_latency", cyc - c0, 16 * (2 + 3));
        check("s2_tt", {16'd0, tt2}, 32'hFFFF);
        check("s2_match", {31'd0, match2}, 32'd1);
        check("s2_mask", {16'd0, mask2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
